// File: rtl/battle_sound_pkg.sv
// Shared widths, LFSR taps and channel levels for the battle sound mixer.
package battle_sound_pkg;

   localparam int unsigned ENV_W       = 4;
   localparam int unsigned MIX_W       = 6;
   localparam int unsigned LFSR_W      = 16;
   localparam int unsigned LFSR_TAP_LO = 3;
   localparam int unsigned LFSR_TAP_HI = 14;
   localparam int unsigned PHASE_W     = 8;
   localparam int unsigned ENG_INC_LO  = 3;
   localparam int unsigned ENG_INC_HI  = 6;
   localparam int unsigned POKEY_LVL   = 8;
   localparam int unsigned ENGINE_LVL  = 4;

   localparam logic [ENV_W-1:0] ENV_MAX = '1;

   // XNOR feedback: the all-zero state is a legal start and shifts in a 1.
   function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
      return {s[LFSR_W-2:0], ~(s[LFSR_TAP_LO] ^ s[LFSR_TAP_HI])};
   endfunction

endpackage

// File: rtl/sound_envelope.sv
// Trigger edge detect plus prescaled, saturating 4-bit decay envelope.
module sound_envelope
   import battle_sound_pkg::*;
#(
   parameter int unsigned DECAY = 64
)
(
   input  logic             clk,
   input  logic             rst_l,
   input  logic             i_sample_en,
   input  logic             i_sound_en,
   input  logic             i_trig,
   output logic [ENV_W-1:0] o_env
);

   localparam int unsigned PRE_W = (DECAY > 1) ? $clog2(DECAY) : 1;

   logic             r_trig;
   logic [PRE_W-1:0] r_pre;
   logic [ENV_W-1:0] r_env;
   logic             w_edge;
   logic             w_wrap;

   assign w_edge = i_trig & ~r_trig;
   assign w_wrap = (r_pre == PRE_W'(DECAY - 1));
   assign o_env  = r_env;

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) r_trig <= 1'b0;
      else        r_trig <= i_trig;
   end

   // Edge beats a coincident decay step; sound disable forces silence.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         r_pre <= '0;
         r_env <= '0;
      end else if (!i_sound_en) begin
         r_pre <= '0;
         r_env <= '0;
      end else if (w_edge) begin
         r_pre <= '0;
         r_env <= ENV_MAX;
      end else if (i_sample_en) begin
         if (w_wrap) begin
            r_pre <= '0;
            if (r_env != '0) r_env <= r_env - ENV_W'(1);
         end else begin
            r_pre <= r_pre + PRE_W'(1);
         end
      end
   end

endmodule

// File: rtl/battle_sound_mixer.sv
// Discrete battle sounds (shell, explosion, engine) mixed with POKEY into a 6-bit PWM.
module battle_sound_mixer
   import battle_sound_pkg::*;
#(
   parameter int unsigned DECAY_SHELL = 64,
   parameter int unsigned DECAY_EXPLO = 128
)
(
   input  logic             clk,
   input  logic             rst_l,
   input  logic             sample_en,
   input  logic             sound_en,
   input  logic             shell_trig,
   input  logic             explo_trig,
   input  logic             explo_loud,
   input  logic             engine_rev,
   input  logic             pokey_aud,
   output logic [MIX_W-1:0] mix_level,
   output logic             aud_pwm
);

   logic [LFSR_W-1:0]  r_lfsr;
   logic [PHASE_W-1:0] r_phase;
   logic [MIX_W-1:0]   r_pwm_cnt;

   logic [ENV_W-1:0]   w_env_shell;
   logic [ENV_W-1:0]   w_env_explo;
   logic               w_noise_a;
   logic               w_noise_b;
   logic [MIX_W-1:0]   w_lvl_shell;
   logic [MIX_W-1:0]   w_lvl_explo;
   logic [MIX_W-1:0]   w_lvl_engine;
   logic [MIX_W-1:0]   w_lvl_pokey;
   logic [MIX_W-1:0]   w_sum;

   sound_envelope #(.DECAY(DECAY_SHELL)) u_shell (
      .clk         (clk),
      .rst_l       (rst_l),
      .i_sample_en (sample_en),
      .i_sound_en  (sound_en),
      .i_trig      (shell_trig),
      .o_env       (w_env_shell)
   );

   sound_envelope #(.DECAY(DECAY_EXPLO)) u_explo (
      .clk         (clk),
      .rst_l       (rst_l),
      .i_sample_en (sample_en),
      .i_sound_en  (sound_en),
      .i_trig      (explo_trig),
      .o_env       (w_env_explo)
   );

   assign w_noise_a = r_lfsr[LFSR_W-1];
   assign w_noise_b = ~&r_lfsr[LFSR_W-2:LFSR_W-5];

   // Channel levels; worst case 15+30+4+8 = 57 fits the mix width unsaturated.
   always_comb begin
      w_lvl_shell  = '0;
      w_lvl_explo  = '0;
      w_lvl_engine = '0;
      w_lvl_pokey  = '0;
      if (w_noise_a) w_lvl_shell = MIX_W'(w_env_shell);
      if (w_noise_b) w_lvl_explo = explo_loud ? MIX_W'({w_env_explo, 1'b0}) : MIX_W'(w_env_explo);
      if (r_phase[PHASE_W-1] && sound_en) w_lvl_engine = MIX_W'(ENGINE_LVL);
      if (pokey_aud) w_lvl_pokey = MIX_W'(POKEY_LVL);
      w_sum = w_lvl_shell + w_lvl_explo + w_lvl_engine + w_lvl_pokey;
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         r_lfsr    <= '0;
         r_phase   <= '0;
         mix_level <= '0;
      end else if (sample_en) begin
         r_lfsr    <= sound_en ? lfsr_next(r_lfsr) : '0;
         r_phase   <= r_phase + (engine_rev ? PHASE_W'(ENG_INC_HI) : PHASE_W'(ENG_INC_LO));
         mix_level <= w_sum;
      end
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         r_pwm_cnt <= '0;
         aud_pwm   <= 1'b0;
      end else begin
         r_pwm_cnt <= r_pwm_cnt + MIX_W'(1);
         aud_pwm   <= (r_pwm_cnt < mix_level);
      end
   end

endmodule

// File: tb/tb_battle_sound_mixer.sv
// Self-checking bench for battle_sound_mixer: LFSR vector table, envelope and mix scenarios.
`timescale 1ns/1ps
module tb_battle_sound_mixer;

   localparam int DS = 64;
   localparam int DE = 128;

   logic       clk = 1'b0;
   logic       rst_l = 1'b1;
   logic       sample_en = 1'b0;
   logic       sound_en = 1'b0;
   logic       shell_trig = 1'b0;
   logic       explo_trig = 1'b0;
   logic       explo_loud = 1'b0;
   logic       engine_rev = 1'b0;
   logic       pokey_aud = 1'b0;
   logic [5:0] mix_level;
   logic       aud_pwm;

   int n_cmp = 0;
   int n_bad = 0;
   int sb_q[$];

   logic [15:0] m_lfsr;
   logic [3:0]  m_env_s, m_env_e;
   int          m_pre_s, m_pre_e;
   logic        m_trg_s, m_trg_e;
   logic [7:0]  m_phase;

   typedef struct {
      logic        snd;
      logic [15:0] exp_lfsr;
   } lfsr_vec_t;
   lfsr_vec_t vecs[24];

   always #5 clk = ~clk;

   battle_sound_mixer #(.DECAY_SHELL(DS), .DECAY_EXPLO(DE)) dut (
      .clk        (clk),
      .rst_l      (rst_l),
      .sample_en  (sample_en),
      .sound_en   (sound_en),
      .shell_trig (shell_trig),
      .explo_trig (explo_trig),
      .explo_loud (explo_loud),
      .engine_rev (engine_rev),
      .pokey_aud  (pokey_aud),
      .mix_level  (mix_level),
      .aud_pwm    (aud_pwm)
   );

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] ref_lfsr(input logic [15:0] s);
      logic fb;
      fb = ~(s[3] ^ s[14]);
      return {s[14:0], fb};
   endfunction

   function automatic int model_sum();
      int s;
      s = 0;
      if (m_lfsr[15]) s += int'(m_env_s);
      if (!(&m_lfsr[14:11])) s += explo_loud ? 2 * int'(m_env_e) : int'(m_env_e);
      if (m_phase[7] && sound_en) s += 4;
      if (pokey_aud) s += 8;
      return s;
   endfunction

   task automatic model_reset();
      m_lfsr = '0; m_env_s = '0; m_env_e = '0; m_pre_s = 0; m_pre_e = 0;
      m_trg_s = 1'b0; m_trg_e = 1'b0; m_phase = '0;
   endtask

   task automatic env_model(input logic trig, input int decay, inout logic trg,
                            inout logic [3:0] env, inout int pre);
      logic e;
      e = trig & ~trg;
      trg = trig;
      if (!sound_en) begin
         env = 4'd0; pre = 0;
      end else if (e) begin
         env = 4'd15; pre = 0;
      end else if (sample_en) begin
         if (pre == decay - 1) begin
            pre = 0;
            if (env != 4'd0) env = env - 4'd1;
         end else begin
            pre++;
         end
      end
   endtask

   task automatic model_update();
      if (!rst_l) begin
         model_reset();
      end else begin
         env_model(shell_trig, DS, m_trg_s, m_env_s, m_pre_s);
         env_model(explo_trig, DE, m_trg_e, m_env_e, m_pre_e);
         if (sample_en) begin
            m_lfsr  = sound_en ? ref_lfsr(m_lfsr) : 16'h0000;
            m_phase = m_phase + (engine_rev ? 8'd6 : 8'd3);
         end
      end
   endtask

   // One clock: scoreboard push on a tick, model advance, output compare after the edge.
   task automatic cyc(input logic tick);
      sample_en = tick;
      if (tick && rst_l) sb_q.push_back(model_sum());
      @(posedge clk);
      model_update();
      #1;
      sample_en = 1'b0;
      if (sb_q.size() > 0) check("mix_level", int'(mix_level), sb_q.pop_front());
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) begin
         cyc(1'b1);
         cyc(1'b0);
      end
   endtask

   task automatic pwm_count(output int cnt);
      cnt = 0;
      for (int k = 0; k < 64; k++) begin
         cyc(1'b0);
         if (aud_pwm) cnt++;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [15:0] s;
      int          cnt;
      int          found;

      s = 16'h0000;
      for (int i = 0; i < 24; i++) begin
         vecs[i].snd = (i != 20);
         s = vecs[i].snd ? ref_lfsr(s) : 16'h0000;
         vecs[i].exp_lfsr = s;
      end

      model_reset();
      #2 rst_l = 1'b0;
      #1;
      check("rst_mix", int'(mix_level), 0);
      check("rst_pwm", int'(aud_pwm), 0);
      check("rst_lfsr", int'(dut.r_lfsr), 0);
      cyc(1'b0);
      cyc(1'b0);
      rst_l = 1'b1;
      sound_en = 1'b1;
      cyc(1'b0);

      // LFSR vector table, with one sound-disabled tick clearing it
      for (int i = 0; i < 24; i++) begin
         sound_en = vecs[i].snd;
         cyc(1'b1);
         check("lfsr", int'(dut.r_lfsr), int'(vecs[i].exp_lfsr));
         if (i == 0) check("first_shift_in", int'(dut.r_lfsr[0]), 1);
         cyc(1'b0);
      end

      // Shell decay
      sound_en = 1'b1;
      shell_trig = 1'b1;
      cyc(1'b0);
      check("shell_env_trig", int'(dut.u_shell.r_env), 15);
      ticks(64);
      check("shell_env_64", int'(dut.u_shell.r_env), 14);
      ticks(896);
      check("shell_env_960", int'(dut.u_shell.r_env), 0);
      ticks(20);
      check("shell_env_sat", int'(dut.u_shell.r_env), 0);
      shell_trig = 1'b0;

      // Explosion retrigger at level 5, then edge coincident with decay tick
      explo_trig = 1'b1;
      cyc(1'b0);
      check("explo_env_trig", int'(dut.u_explo.r_env), 15);
      ticks(1280);
      check("explo_env_5", int'(dut.u_explo.r_env), 5);
      explo_trig = 1'b0;
      cyc(1'b0);
      explo_trig = 1'b1;
      cyc(1'b0);
      check("explo_retrig", int'(dut.u_explo.r_env), 15);
      explo_trig = 1'b0;
      cyc(1'b0);
      ticks(127);
      check("explo_pre_coinc", int'(dut.u_explo.r_env), 15);
      explo_trig = 1'b1;
      cyc(1'b1);
      check("explo_coinc", int'(dut.u_explo.r_env), 15);
      cyc(1'b0);

      // Loud explosion plus POKEY, engine quiet
      pokey_aud = 1'b1;
      explo_loud = 1'b1;
      found = 0;
      for (int k = 0; k < 120 && found == 0; k++) begin
         if (!m_phase[7] && !(&m_lfsr[14:11]) && m_env_e == 4'd15 && m_env_s == 4'd0) begin
            cyc(1'b1);
            found = 1;
         end else begin
            ticks(1);
         end
      end
      check("loud_window", found, 1);
      if (found != 0) begin
         check("mix_loud", int'(mix_level), 38);
         cyc(1'b0);
         cyc(1'b0);
         pwm_count(cnt);
         check("pwm_38", cnt, 38);
      end

      // Sound disable during a shell sound
      explo_loud = 1'b0;
      explo_trig = 1'b0;
      pokey_aud = 1'b0;
      cyc(1'b0);
      shell_trig = 1'b1;
      cyc(1'b0);
      ticks(5);
      check("shell_env_active", int'(dut.u_shell.r_env), 15);
      sound_en = 1'b0;
      pokey_aud = 1'b1;
      cyc(1'b0);
      cyc(1'b1);
      check("off_lfsr", int'(dut.r_lfsr), 0);
      check("off_env_s", int'(dut.u_shell.r_env), 0);
      check("off_env_e", int'(dut.u_explo.r_env), 0);
      check("off_mix_pokey", int'(mix_level), 8);
      cyc(1'b0);
      pwm_count(cnt);
      check("pwm_8", cnt, 8);
      pokey_aud = 1'b0;
      cyc(1'b1);
      check("mix_zero", int'(mix_level), 0);
      cyc(1'b0);
      pwm_count(cnt);
      check("pwm_0", cnt, 0);

      // Trigger held high through reset release fires once
      sound_en = 1'b1;
      rst_l = 1'b0;
      #1;
      model_reset();
      sb_q.delete();
      cyc(1'b0);
      cyc(1'b0);
      check("rst_hold_env", int'(dut.u_shell.r_env), 0);
      rst_l = 1'b1;
      cyc(1'b0);
      check("rel_fire", int'(dut.u_shell.r_env), 15);
      pokey_aud = 1'b1;
      ticks(64);
      check("rel_once", int'(dut.u_shell.r_env), 14);

      // Asynchronous reset mid-cycle aborts the envelope
      #2;
      rst_l = 1'b0;
      #1;
      check("arst_mix", int'(mix_level), 0);
      check("arst_pwm", int'(aud_pwm), 0);
      check("arst_env_s", int'(dut.u_shell.r_env), 0);
      check("arst_lfsr", int'(dut.r_lfsr), 0);
      model_reset();
      sb_q.delete();
      cyc(1'b0);
      shell_trig = 1'b0;
      pokey_aud = 1'b0;
      rst_l = 1'b1;
      cyc(1'b0);
      ticks(3);
      check("post_rst_env", int'(dut.u_shell.r_env), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
